// File: rtl/btn_pkg.sv
// Shared types and LFSR step for the button-bounce generator.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE,
    DONE
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Galois step for x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/btn_bounce_gen_lfsr16.sv
// 16-bit Galois LFSR that advances only when asked; a zero seed is replaced by 1.
module lfsr16
  import btn_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] value
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= SEED_EFF;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/btn_bounce_gen.sv
// Mechanical-switch emulator: turns a level command into a seeded chattering
// contact that bounces BOUNCE_COUNT times and settles at the commanded level.
module btn_bounce_gen
  import btn_pkg::*;
#(
  parameter logic        IDLE_STATE         = 1'b1,
  parameter int unsigned BOUNCE_COUNT       = 4,
  parameter int unsigned CHATTER_MAX_CYCLES = 8,
  parameter int unsigned SETTLE_CYCLES      = 16,
  parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  input  logic cmd_level,
  output logic cmd_ready,
  output logic bouncyOut,
  output logic busy,
  output logic done
);

  localparam int unsigned CNT_MAX =
    (CHATTER_MAX_CYCLES > SETTLE_CYCLES) ? CHATTER_MAX_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  localparam logic [8:0]    TOG_INIT    = 9'(2 * BOUNCE_COUNT + 1);
  localparam logic [7:0]    SEG_MASK    = 8'(CHATTER_MAX_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  state_t        state;
  logic          cur;
  logic          target;
  logic [8:0]    tog_left;
  logic [CW-1:0] cnt;
  logic [CW-1:0] seg;
  logic [15:0]   lfsr_val;
  logic [15:0]   lfsr_adv;
  logic          toggle;
  logic          accept;

  assign accept   = (state == IDLE) && cmd_valid && cmd_ready;
  // Counter is cleared on BOUNCE entry so the first edge toggles immediately.
  assign toggle   = (state == BOUNCE) && (cnt <= CNT_ONE);
  assign lfsr_adv = lfsr_next(lfsr_val);
  assign seg      = CW'(lfsr_adv[7:0] & SEG_MASK) + CNT_ONE;

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .advance(toggle),
    .value  (lfsr_val)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cur       <= IDLE_STATE;
      target    <= IDLE_STATE;
      tog_left  <= '0;
      cnt       <= '0;
      bouncyOut <= IDLE_STATE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Status outputs follow the state register by one cycle.
      cmd_ready <= (state == IDLE);
      busy      <= (state != IDLE);
      done      <= (state == DONE);

      case (state)
        IDLE: begin
          bouncyOut <= cur;
          if (accept) begin
            target <= cmd_level;
            if (cmd_level == cur) begin
              state <= DONE;
            end else begin
              tog_left <= TOG_INIT;
              cnt      <= '0;
              state    <= BOUNCE;
            end
          end
        end

        BOUNCE: begin
          if (toggle) begin
            bouncyOut <= ~bouncyOut;
            tog_left  <= tog_left - 9'd1;
            if (tog_left == 9'd1) begin
              cnt   <= SETTLE_INIT;
              state <= SETTLE;
            end else begin
              cnt <= seg;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        SETTLE: begin
          if (cnt <= CNT_ONE) begin
            cur   <= target;
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_bounce_gen.sv
// Self-checking bench: fixed vector table on a one-cycle-chatter instance and
// a queue scoreboard with an independent bounce model on a default instance.
module tb_btn_bounce_gen;

  localparam int unsigned BC   = 4;
  localparam int unsigned CHM  = 8;
  localparam int unsigned SC   = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int unsigned T    = 2 * BC + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic g_valid = 1'b0, g_level = 1'b0;
  logic g_ready, g_bo, g_busy, g_done;
  logic d_valid = 1'b0, d_level = 1'b0;
  logic d_ready, d_bo, d_busy, d_done;

  // Observation vectors: {bouncyOut, busy, cmd_ready, done}
  logic [3:0] g_obs, d_obs;
  assign g_obs = {g_bo, g_busy, g_ready, g_done};
  assign d_obs = {d_bo, d_busy, d_ready, d_done};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_bounce_gen #(
    .IDLE_STATE        (1'b1),
    .BOUNCE_COUNT      (BC),
    .CHATTER_MAX_CYCLES(CHM),
    .SETTLE_CYCLES     (SC),
    .LFSR_SEED         (SEED)
  ) u_gen (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(g_valid),
    .cmd_level(g_level),
    .cmd_ready(g_ready),
    .bouncyOut(g_bo),
    .busy     (g_busy),
    .done     (g_done)
  );

  btn_bounce_gen #(
    .IDLE_STATE        (1'b1),
    .BOUNCE_COUNT      (2),
    .CHATTER_MAX_CYCLES(1),
    .SETTLE_CYCLES     (4),
    .LFSR_SEED         (16'h1234)
  ) u_det (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(d_valid),
    .cmd_level(d_level),
    .cmd_ready(d_ready),
    .bouncyOut(d_bo),
    .busy     (d_busy),
    .done     (d_done)
  );

  typedef struct packed {
    logic       valid;
    logic       level;
    logic [3:0] exp;
    logic [3:0] mask;
  } vec_t;

  typedef struct packed {
    logic [3:0] v;
    logic [3:0] m;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];

  logic [15:0] m_lfsr;
  logic        m_cur;

  task automatic chk(input string name, input logic [3:0] act,
                     input logic [3:0] exp, input logic [3:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: got {bo,busy,rdy,done}=%b expected %b (mask %b) at %0t",
               name, act, exp, mask, $time);
    end
  endtask

  task automatic add(input logic v, input logic l, input logic [3:0] e,
                     input logic [3:0] m);
    vec_t r;
    r.valid = v; r.level = l; r.exp = e; r.mask = m;
    tbl.push_back(r);
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  task automatic push_exp(input logic [3:0] v, input logic [3:0] m);
    exp_t e;
    e.v = v; e.m = m;
    sbq.push_back(e);
  endtask

  // Expected per-cycle trace from the cycle after acceptance onwards.
  task automatic push_cmd(input logic lvl);
    logic        b;
    int unsigned hold;
    push_exp({m_cur, 3'b000}, 4'b1000);
    if (lvl == m_cur) begin
      push_exp({m_cur, 3'b101}, 4'hF);
      push_exp({m_cur, 3'b010}, 4'hF);
    end else begin
      b = m_cur;
      for (int unsigned i = 1; i <= T; i++) begin
        b = ~b;
        m_lfsr = m_step(m_lfsr);
        if (i == T) hold = SC + 1;
        else        hold = 32'(m_lfsr[7:0] & 8'(CHM - 1)) + 1;
        repeat (hold) push_exp({b, 3'b100}, 4'hF);
      end
      push_exp({b, 3'b101}, 4'hF);
      push_exp({b, 3'b010}, 4'hF);
      m_cur = lvl;
    end
  endtask

  task automatic run_cmd(input logic lvl, input int id);
    exp_t e;
    int   k;
    g_valid = 1'b1;
    g_level = lvl;
    push_cmd(lvl);
    k = 0;
    while (sbq.size() > 0) begin
      @(negedge clk);
      g_valid = 1'b0;
      e = sbq.pop_front();
      chk($sformatf("gen_cmd%0d_k%0d", id, k), g_obs, e.v, e.m);
      k++;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("gen_post_reset", g_obs, 4'b1010, 4'hF);
    m_lfsr = SEED;
    m_cur  = 1'b1;
    sbq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   n;
    logic prev;

    // Cycle table for BOUNCE_COUNT=2, CHATTER_MAX_CYCLES=1, SETTLE_CYCLES=4.
    add(1, 0, 4'b1000, 4'b1000);
    add(0, 0, 4'b0100, 4'hF);
    add(0, 0, 4'b1100, 4'hF);
    add(1, 1, 4'b0100, 4'hF);   // offered while busy: must be ignored
    add(0, 0, 4'b1100, 4'hF);
    add(0, 0, 4'b0100, 4'hF);
    for (int i = 0; i < 4; i++) add(0, 0, 4'b0100, 4'hF);
    add(0, 0, 4'b0101, 4'hF);
    add(0, 0, 4'b0010, 4'hF);
    add(1, 0, 4'b0000, 4'b1000); // same-level command
    add(0, 0, 4'b0101, 4'hF);
    add(0, 0, 4'b0010, 4'hF);
    add(1, 1, 4'b0000, 4'b1000);
    add(0, 0, 4'b1100, 4'hF);
    add(0, 0, 4'b0100, 4'hF);
    add(0, 0, 4'b1100, 4'hF);
    add(0, 0, 4'b0100, 4'hF);
    add(0, 0, 4'b1100, 4'hF);
    for (int i = 0; i < 4; i++) add(0, 0, 4'b1100, 4'hF);
    add(0, 0, 4'b1101, 4'hF);
    add(0, 0, 4'b1010, 4'hF);

    reset   = 1'b0;
    g_valid = 1'b1;
    d_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("reset_gen", g_obs, 4'b1000, 4'hF);
      chk("reset_det", d_obs, 4'b1000, 4'hF);
    end
    g_valid = 1'b0;
    d_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    chk("ready_gen", g_obs, 4'b1010, 4'hF);
    chk("ready_det", d_obs, 4'b1010, 4'hF);

    for (int i = 0; i < tbl.size(); i++) begin
      d_valid = tbl[i].valid;
      d_level = tbl[i].level;
      @(negedge clk);
      chk($sformatf("det_vec%0d", i), d_obs, tbl[i].exp, tbl[i].mask);
    end
    d_valid = 1'b0;

    m_lfsr = SEED;
    m_cur  = 1'b1;
    for (int i = 0; i < 20; i++) run_cmd((i % 2 == 0) ? 1'b0 : 1'b1, i);

    do_reset(2);
    for (int i = 0; i < 20; i++) run_cmd((i % 2 == 0) ? 1'b0 : 1'b1, 20 + i);

    do_reset(2);
    g_valid = 1'b1;
    g_level = 1'b0;
    @(negedge clk);
    g_valid = 1'b0;
    n = 0;
    prev = 1'b1;
    for (int c = 0; c < 100 && n < 3; c++) begin
      @(negedge clk);
      if (g_bo !== prev) begin
        n++;
        prev = g_bo;
      end
    end
    checks++;
    if (n < 3) begin
      errors++;
      $display("FAIL midreset_wait: saw %0d toggles, required 3", n);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_out", g_obs, 4'b1000, 4'hF);
    repeat (2) begin
      @(negedge clk);
      chk("midreset_nodone", g_obs, 4'b0000, 4'b0001);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_ready", g_obs, 4'b1010, 4'hF);
    m_lfsr = SEED;
    m_cur  = 1'b1;
    sbq.delete();
    run_cmd(1'b0, 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
